uart_tx_arbiter: RTL and testbench

Shares one uart_tx transmitter between NUM_REQ byte producers using round-robin arbitration. It latches the granted requester's byte and pulses tx_en to uart_tx. It then waits for uart_tx's tx_done and reports per-requester acknowledge and completion. A watchdog flags a transmitter that never completes a frame.

---
 rtl/uart_tx_arbiter_pkg.sv | 27 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the UART transmit arbiter: serial timing
// derived from the 50 MHz clock, the FSM state type and a counter-width helper.
package uart_tx_arbiter_pkg;

   localparam int CLK_FREQ     = 50_000_000;
   localparam int BAUD         = 115_200;
   localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

   // Two frames of margin, rounded down to a whole thousand clocks.
   localparam int DEF_TIMEOUT_CYCLES = ((2 * FRAME_CLKS) / 1000) * 1000;

   localparam int DATA_W = 8;
   localparam int ID_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_DONE,
      ST_GAP
   } arb_state_t;

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle shared between the arbiter
// (master side) and its environment (slave side).
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import uart_tx_arbiter_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [DATA_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        done;
   logic                      tx_en;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_done;
   logic                      busy;
   logic [ID_W-1:0]           grant_id;
   logic                      timeout_err;

   modport master (
      input  req, req_data, tx_done,
      output ack, done, tx_en, tx_data, busy, grant_id, timeout_err
   );

   modport slave (
      output req, req_data, tx_done,
      input  ack, done, tx_en, tx_data, busy, grant_id, timeout_err
   );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin selector: first asserted request at or above the
// pointer, wrapping around, plus a flag telling whether any request is set.
module rr_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   logic [NUM_REQ-1:0] rot;
   int                 sum;

   // Rotate so bit 0 is the pointer position; descending scan leaves the
   // lowest rotated offset as the final winner.
   always_comb begin
      rot       = NUM_REQ'({req, req} >> ptr);
      grant_idx = '0;
      grant_vld = 1'b0;
      sum       = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            grant_idx = ID_W'(sum);
            grant_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers: round-robin grant, one-cycle
// launch, wait for tx_done rising edge, optional idle gap, and a frame watchdog.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input logic               clk_50M,
   input logic               rst,
   uart_tx_arbiter_if.master bus
);

   localparam int WD_W  = cnt_w(TIMEOUT_CYCLES);
   localparam int GAP_W = cnt_w(GAP_CYCLES);

   arb_state_t         state_q, state_d, after_frame;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    rr_idx;
   logic               rr_vld;
   logic [NUM_REQ-1:0] grant_oh;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               tx_done_q;
   logic               timeout_q, timeout_d;
   logic               done_edge;
   logic               wd_expired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req       (bus.req),
      .ptr       (ptr_q),
      .grant_idx (rr_idx),
      .grant_vld (rr_vld)
   );

   assign grant_oh    = NUM_REQ'(1) << grant_q;
   assign done_edge   = bus.tx_done & ~tx_done_q;
   assign wd_expired  = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign after_frame = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      tx_data_d   = tx_data_q;
      wd_d        = wd_q;
      gap_d       = gap_q;
      timeout_d   = timeout_q;
      bus.ack     = '0;
      bus.done    = '0;
      bus.tx_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rr_vld) begin
               grant_d = rr_idx;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (rr_idx == ID_W'(i)) tx_data_d = bus.req_data[i*DATA_W +: DATA_W];
               end
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            bus.tx_en = 1'b1;
            bus.ack   = grant_oh;
            ptr_d     = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
            wd_d      = '0;
            state_d   = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            wd_d = wd_q + 1'b1;
            // A completion edge in the expiry cycle still counts as success.
            if (done_edge) begin
               bus.done = grant_oh;
               gap_d    = '0;
               state_d  = after_frame;
            end else if (wd_expired) begin
               timeout_d = 1'b1;
               gap_d     = '0;
               state_d   = after_frame;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         grant_q   <= '0;
         tx_data_q <= '0;
         wd_q      <= '0;
         gap_q     <= '0;
         tx_done_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         tx_data_q <= tx_data_d;
         wd_q      <= wd_d;
         gap_q     <= gap_d;
         tx_done_q <= bus.tx_done;
         timeout_q <= timeout_d;
      end
   end

   assign bus.tx_data     = tx_data_q;
   assign bus.grant_id    = grant_q;
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a queue-free round-robin
// reference model and a behavioural transmitter driven from the test tasks.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int GAP   = 5;
   localparam int TMO   = 100;
   localparam int FRAME = 40;
   localparam int LIMIT = 400;

   logic clk_50M = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   ptr_m;
   logic [7:0] data_m [N];

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_50M (clk_50M),
      .rst     (rst),
      .bus     (bus)
   );

   always #10 clk_50M = ~clk_50M;

   initial begin
      #(20 * 60000);
      $display("FAIL global_time_limit got running exp finished");
      $fatal(1, "time limit");
   end

   // Reference grant rule: first set request at or after the pointer, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return (i < 0) ? '0 : (N'(1) << i);
   endfunction

   task automatic drive_data();
      for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = data_m[i];
   endtask

   task automatic apply_reset();
      bus.req     = '0;
      bus.tx_done = 1'b0;
      rst         = 1'b1;
      repeat (2) @(posedge clk_50M);
      #1 rst = 1'b0;
      ptr_m = 0;
   endtask

   task automatic wait_launch(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < LIMIT; i++) begin
         @(negedge clk_50M);
         cyc = i + 1;
         if (bus.tx_en === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.tx_done  = 1'b0;
      #5;
      tests++;
      if ({bus.busy, bus.tx_en, bus.ack, bus.done, bus.tx_data, bus.grant_id, bus.timeout_err} !== '0) begin
         fails++;
         $display("FAIL reset_outputs got busy=%b tx_en=%b ack=%b done=%b data=%h id=%0d to=%b exp all 0",
                  bus.busy, bus.tx_en, bus.ack, bus.done, bus.tx_data, bus.grant_id, bus.timeout_err);
      end
   endtask

   task automatic test_single();
      apply_reset();
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      data_m[2] = 8'h5A;
      drive_data();
      @(posedge clk_50M);
      #1 bus.req = 4'b0100;
      @(negedge clk_50M);
      tests++;
      if (bus.tx_en !== 1'b0) begin
         fails++;
         $display("FAIL single_latency got tx_en=%b exp 0", bus.tx_en);
      end
      @(negedge clk_50M);
      tests++;
      if ({bus.tx_en, bus.ack, bus.grant_id, bus.tx_data, bus.busy} !== {1'b1, 4'b0100, 3'd2, 8'h5A, 1'b1}) begin
         fails++;
         $display("FAIL single_launch got tx_en=%b ack=%b id=%0d data=%h busy=%b exp 1 0100 2 5a 1",
                  bus.tx_en, bus.ack, bus.grant_id, bus.tx_data, bus.busy);
      end
      bus.req = '0;
      ptr_m   = 3;
      @(negedge clk_50M);
      tests++;
      if ({bus.tx_en, bus.ack} !== 5'b0) begin
         fails++;
         $display("FAIL single_pulse_width got tx_en=%b ack=%b exp 0 0000", bus.tx_en, bus.ack);
      end
      repeat (FRAME - 1) @(posedge clk_50M);
      #1 bus.tx_done = 1'b1;
      @(negedge clk_50M);
      tests++;
      if ({bus.done, bus.ack} !== {4'b0100, 4'b0000}) begin
         fails++;
         $display("FAIL single_done got done=%b ack=%b exp 0100 0000", bus.done, bus.ack);
      end
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
      @(negedge clk_50M);
      tests++;
      if (bus.done !== 4'b0000) begin
         fails++;
         $display("FAIL single_done_width got %b exp 0000", bus.done);
      end
      repeat (GAP + 1) @(negedge clk_50M);
      tests++;
      if ({bus.busy, bus.tx_en} !== 2'b00) begin
         fails++;
         $display("FAIL single_idle_after got busy=%b tx_en=%b exp 0 0", bus.busy, bus.tx_en);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_seq [8];
      bit ok;
      int cyc, exp_id;
      bit stable;
      exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44};
      apply_reset();
      data_m = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_data();
      @(posedge clk_50M);
      #1 bus.req = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         wait_launch(ok, cyc);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL b2b_launch_timeout frame=%0d got no tx_en exp tx_en", k);
            return;
         end
         exp_id = rr_pick(bus.req, ptr_m);
         ptr_m  = (exp_id + 1) % N;
         tests++;
         if ({bus.ack, bus.grant_id, bus.tx_data} !== {onehot(exp_id), 3'(exp_id), exp_seq[k]}) begin
            fails++;
            $display("FAIL b2b_grant frame=%0d got ack=%b id=%0d data=%h exp %b %0d %h",
                     k, bus.ack, bus.grant_id, bus.tx_data, onehot(exp_id), exp_id, exp_seq[k]);
         end
         if (k > 0) begin
            tests++;
            if (cyc != GAP + 2) begin
               fails++;
               $display("FAIL b2b_gap_spacing frame=%0d got %0d exp %0d", k, cyc, GAP + 2);
            end
         end
         stable = 1'b1;
         for (int j = 0; j < FRAME; j++) begin
            @(posedge clk_50M);
            if (bus.tx_data !== exp_seq[k]) stable = 1'b0;
         end
         #1 bus.tx_done = 1'b1;
         @(negedge clk_50M);
         tests++;
         if ({bus.done, stable} !== {onehot(exp_id), 1'b1}) begin
            fails++;
            $display("FAIL b2b_done frame=%0d got done=%b stable=%b exp %b 1", k, bus.done, stable, onehot(exp_id));
         end
         @(posedge clk_50M);
         #1 bus.tx_done = 1'b0;
      end
      bus.req = '0;
   endtask

   task automatic test_random();
      bit ok;
      int cyc, exp_id, flen;
      logic [N-1:0] r;
      apply_reset();
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      drive_data();
      @(posedge clk_50M);
      #1 bus.req = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < 12; k++) begin
         wait_launch(ok, cyc);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL rand_launch_timeout frame=%0d got no tx_en exp tx_en", k);
            return;
         end
         exp_id = rr_pick(bus.req, ptr_m);
         ptr_m  = (exp_id + 1) % N;
         tests++;
         if ({bus.ack, bus.grant_id, bus.tx_data} !== {onehot(exp_id), 3'(exp_id), data_m[exp_id]}) begin
            fails++;
            $display("FAIL rand_grant frame=%0d got ack=%b id=%0d data=%h exp %b %0d %h",
                     k, bus.ack, bus.grant_id, bus.tx_data, onehot(exp_id), exp_id, data_m[exp_id]);
         end
         r          = bus.req;
         r[exp_id]  = 1'($urandom_range(0, 1));
         r          = (r & N'($urandom | $urandom)) | N'($urandom & $urandom);
         if (r == '0) r = onehot($urandom_range(0, N - 1));
         data_m[exp_id] = 8'($urandom);
         drive_data();
         bus.req = r;
         flen = $urandom_range(5, 60);
         repeat (flen) @(posedge clk_50M);
         #1 bus.tx_done = 1'b1;
         @(negedge clk_50M);
         tests++;
         if (bus.done !== onehot(exp_id)) begin
            fails++;
            $display("FAIL rand_done frame=%0d got %b exp %b", k, bus.done, onehot(exp_id));
         end
         @(posedge clk_50M);
         #1 bus.tx_done = 1'b0;
      end
      bus.req = '0;
   endtask

   task automatic test_withdraw_simul();
      bit ok;
      int cyc;
      apply_reset();
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      drive_data();
      @(posedge clk_50M);
      #1 bus.req = 4'b0001;
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack} !== {1'b1, 4'b0001}) begin
         fails++;
         $display("FAIL wd_first_grant got ok=%b ack=%b exp 1 0001", ok, bus.ack);
      end
      bus.req = 4'b1010;
      repeat (10) @(negedge clk_50M);
      bus.req = 4'b1000;
      repeat (20) @(posedge clk_50M);
      #1 bus.tx_done = 1'b1;
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack, bus.grant_id, bus.tx_data} !== {1'b1, 4'b1000, 3'd3, data_m[3]}) begin
         fails++;
         $display("FAIL withdraw_grant got ok=%b ack=%b id=%0d data=%h exp 1 1000 3 %h",
                  ok, bus.ack, bus.grant_id, bus.tx_data, data_m[3]);
      end
      bus.req = '0;
      repeat (TMO) @(posedge clk_50M);
      #1 bus.tx_done = 1'b1;
      @(negedge clk_50M);
      tests++;
      if (bus.done !== 4'b1000) begin
         fails++;
         $display("FAIL simul_done got %b exp 1000", bus.done);
      end
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
      repeat (3) @(negedge clk_50M);
      tests++;
      if (bus.timeout_err !== 1'b0) begin
         fails++;
         $display("FAIL simul_no_timeout got %b exp 0", bus.timeout_err);
      end
   endtask

   task automatic test_level();
      bit ok, seen;
      int cyc;
      apply_reset();
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      drive_data();
      bus.tx_done = 1'b1;
      @(posedge clk_50M);
      #1 bus.req = 4'b0010;
      wait_launch(ok, cyc);
      bus.req = '0;
      seen    = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk_50M);
         if (bus.done !== 4'b0000) seen = 1'b1;
      end
      tests++;
      if ({ok, seen} !== 2'b10) begin
         fails++;
         $display("FAIL level_not_completion got ok=%b done_seen=%b exp 1 0", ok, seen);
      end
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b1;
      @(negedge clk_50M);
      tests++;
      if (bus.done !== 4'b0010) begin
         fails++;
         $display("FAIL level_new_edge got %b exp 0010", bus.done);
      end
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
   endtask

   task automatic test_stuck();
      bit ok, seen;
      int cyc, rise;
      apply_reset();
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      drive_data();
      @(posedge clk_50M);
      #1 bus.req = 4'b0101;
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack} !== {1'b1, 4'b0001}) begin
         fails++;
         $display("FAIL stuck_first_grant got ok=%b ack=%b exp 1 0001", ok, bus.ack);
      end
      bus.req = 4'b0100;
      seen    = 1'b0;
      rise    = -1;
      for (int j = 1; j <= 3 * TMO; j++) begin
         @(negedge clk_50M);
         if (bus.done !== 4'b0000) seen = 1'b1;
         if (bus.timeout_err === 1'b1) begin
            rise = j;
            break;
         end
      end
      // Launch cycle, then TMO watchdog cycles; the sticky flag shows one edge later.
      tests++;
      if (rise != TMO + 1 || seen) begin
         fails++;
         $display("FAIL stuck_timeout got rise=%0d done_seen=%b exp %0d 0", rise, seen, TMO + 1);
      end
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack, bus.grant_id, bus.timeout_err} !== {1'b1, 4'b0100, 3'd2, 1'b1}) begin
         fails++;
         $display("FAIL stuck_next_grant got ok=%b ack=%b id=%0d to=%b exp 1 0100 2 1",
                  ok, bus.ack, bus.grant_id, bus.timeout_err);
      end
      bus.req = '0;
      ptr_m   = 3;
      repeat (FRAME) @(posedge clk_50M);
      #1 bus.tx_done = 1'b1;
      @(negedge clk_50M);
      tests++;
      if ({bus.done, bus.timeout_err} !== {4'b0100, 1'b1}) begin
         fails++;
         $display("FAIL stuck_sticky got done=%b to=%b exp 0100 1", bus.done, bus.timeout_err);
      end
      @(posedge clk_50M);
      #1 bus.tx_done = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int cyc, exp_id;
      for (int i = 0; i < N; i++) data_m[i] = 8'($urandom);
      drive_data();
      bus.req = 4'b1001;
      exp_id  = rr_pick(bus.req, ptr_m);
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack} !== {1'b1, onehot(exp_id)}) begin
         fails++;
         $display("FAIL mid_grant got ok=%b ack=%b exp 1 %b", ok, bus.ack, onehot(exp_id));
      end
      repeat (5) @(negedge clk_50M);
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({bus.busy, bus.tx_en, bus.ack, bus.done, bus.tx_data, bus.grant_id, bus.timeout_err} !== '0) begin
         fails++;
         $display("FAIL mid_async_reset got busy=%b tx_en=%b ack=%b done=%b data=%h id=%0d to=%b exp all 0",
                  bus.busy, bus.tx_en, bus.ack, bus.done, bus.tx_data, bus.grant_id, bus.timeout_err);
      end
      @(posedge clk_50M);
      #1 rst = 1'b0;
      ptr_m  = 0;
      exp_id = rr_pick(bus.req, ptr_m);
      wait_launch(ok, cyc);
      tests++;
      if ({ok, bus.ack, bus.grant_id, bus.tx_data} !== {1'b1, onehot(exp_id), 3'(exp_id), data_m[exp_id]}) begin
         fails++;
         $display("FAIL mid_after_release got ok=%b ack=%b id=%0d data=%h exp 1 %b %0d %h",
                  ok, bus.ack, bus.grant_id, bus.tx_data, onehot(exp_id), exp_id, data_m[exp_id]);
      end
      bus.req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_withdraw_simul();
      test_level();
      test_stuck();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
